// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// input_debouncer_pkg
// Shared definitions for the two-channel input debouncer:
//   - db_state_e   : per-channel debounce FSM state encoding
//   - DEFAULT_*    : default synchroniser depth, stability count and counter width
//   - db_is_high() : debounced output level implied by an FSM state
// -----------------------------------------------------------------------------
package input_debouncer_pkg;

    // The encoding is fixed so that bit 1 is the debounced level:
    // STABLE_HI and WAIT_LO report 1, STABLE_LO and WAIT_HI report 0.
    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'b00,
        DB_WAIT_HI   = 2'b01,
        DB_STABLE_HI = 2'b11,
        DB_WAIT_LO   = 2'b10
    } db_state_e;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_STABLE_CNT  = 50000;   // ~1 ms at 50 MHz
    localparam int DEFAULT_CNT_W       = 16;

    function automatic logic db_is_high(input db_state_e st);
        return (st == DB_STABLE_HI) || (st == DB_WAIT_LO);
    endfunction

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_channel.sv
// -----------------------------------------------------------------------------
// input_debouncer_channel
// One debounce channel: synchroniser chain, stability counter, debounce FSM
// and registered edge pulses.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   raw    in   raw switch level, asynchronous to clk
//   level  out  debounced level (registered)
//   rise   out  one-cycle pulse on the first cycle of a new high level
//   fall   out  one-cycle pulse on the first cycle of a new low level
//
// A level change is accepted only after STABLE_CNT consecutive identical
// synchronised samples; any disagreeing sample restarts the window.
// -----------------------------------------------------------------------------
module input_debouncer_channel
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_debouncer_channel: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CNT < 2) begin : g_bad_cnt
        $error("input_debouncer_channel: STABLE_CNT must be >= 2");
    end
    if ((2.0 ** CNT_W) <= STABLE_CNT) begin : g_bad_width
        $error("input_debouncer_channel: CNT_W too narrow for STABLE_CNT");
    end

    // Terminal count: the sample that completes the stability window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser chain: stage 0 captures raw, the last stage feeds the FSM.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    assign sync_d[0] = raw;

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM, counter and output registers.
    // ------------------------------------------------------------------
    db_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              level_q, level_d;
    logic              rise_q,  rise_d;
    logic              fall_q,  fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            DB_STABLE_LO: begin
                if (s) begin
                    // The first high sample already counts toward the window.
                    state_d = DB_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            DB_WAIT_HI: begin
                if (!s) begin
                    state_d = DB_STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            DB_STABLE_HI: begin
                if (!s) begin
                    state_d = DB_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            DB_WAIT_LO: begin
                if (s) begin
                    state_d = DB_STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = DB_STABLE_LO;
                cnt_d   = '0;
            end
        endcase

        // Level is registered alongside the state so it changes in the same
        // cycle as the rise/fall pulse.
        level_d = db_is_high(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= DB_STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : input_debouncer_channel

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Two independent debounce channels conditioning raw switch levels A_raw and
// B_raw into clean, clk-synchronous levels for the downstream two-input gates,
// plus one-cycle rise/fall pulses per channel.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   A_raw   in   raw switch level, channel A (asynchronous)
//   B_raw   in   raw switch level, channel B (asynchronous)
//   A, B    out  debounced levels
//   A_rise  out  1-cycle pulse when A goes 0->1
//   A_fall  out  1-cycle pulse when A goes 1->0
//   B_rise  out  1-cycle pulse when B goes 0->1
//   B_fall  out  1-cycle pulse when B goes 1->0
//
// Latency from the first edge that samples a new raw level to the output
// change is SYNC_STAGES + STABLE_CNT edges.
// -----------------------------------------------------------------------------
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic A_raw,
    input  logic B_raw,
    output logic A,
    output logic B,
    output logic A_rise,
    output logic A_fall,
    output logic B_rise,
    output logic B_fall
);

    input_debouncer_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT),
        .CNT_W       (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (A_raw),
        .level (A),
        .rise  (A_rise),
        .fall  (A_fall)
    );

    input_debouncer_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT),
        .CNT_W       (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (B_raw),
        .level (B),
        .rise  (B_rise),
        .fall  (B_fall)
    );

endmodule : input_debouncer
